// File: rtl/glyph_fetch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glyph_fetch_arbiter_pkg
// Brief    : Shared display constants for glyph fetch. Pixel bit 0 is the
//            leftmost pixel of a glyph row.
// Revision : 1.0 - initial release
// ============================================================================
package glyph_fetch_arbiter_pkg;

    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;
    localparam int ROW_W   = 4;

    // Pointer increment that wraps for any requester count, power of two or not.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/glyph_fetch_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : glyph_fetch_arbiter_if
// Brief    : Requester, ROM-bank and response bundle of the glyph fetch arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface glyph_fetch_arbiter_if
    import glyph_fetch_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int CODE_W = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*CODE_W-1:0] req_code;
    logic [NREQ*ROW_W-1:0]  req_row;
    logic [NREQ-1:0]        req_ready;
    logic [CODE_W-1:0]      rom_code;
    logic [ROW_W-1:0]       rom_addr;
    logic [GLYPH_W-1:0]     rom_data;
    logic [NREQ-1:0]        rsp_valid;
    logic [GLYPH_W-1:0]     rsp_data;
    logic [ID_W-1:0]        rsp_id;

    // Environment side: requesters plus the ROM bank
    modport master (
        output req_valid, req_code, req_row, rom_data,
        input  req_ready, rom_code, rom_addr, rsp_valid, rsp_data, rsp_id
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_code, req_row, rom_data,
        output req_ready, rom_code, rom_addr, rsp_valid, rsp_data, rsp_id
    );

endinterface
`default_nettype wire

// File: rtl/glyph_fetch_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : One-hot priority picker, round-robin from a pointer or fixed
//            priority (index 0 highest); reusable for shared display resources.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  wire logic                 i_en,
    input  wire logic                 i_fixed_pri,
    input  wire logic [N-1:0]         i_req,
    input  wire logic [$clog2(N)-1:0] i_ptr,
    output logic      [N-1:0]         o_grant,
    output logic      [$clog2(N)-1:0] o_grant_idx,
    output logic                      o_grant_any
);
    localparam int PW = $clog2(N);

    always_comb begin
        int j;
        j           = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        if (i_en) begin
            // Fixed mode scans from 0; round-robin scans from the pointer with wrap.
            for (int k = 0; k < N; k++) begin
                j = i_fixed_pri ? k : int'(i_ptr) + k;
                if (j >= N) begin
                    j = j - N;
                end
                if (!o_grant_any && i_req[j]) begin
                    o_grant[j]  = 1'b1;
                    o_grant_idx = PW'(j);
                    o_grant_any = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/glyph_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : glyph_fetch_arbiter
// Brief    : Shares one glyph ROM bank among NREQ requesters; grants one per
//            cycle and returns the registered row one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module glyph_fetch_arbiter
    import glyph_fetch_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int CODE_W = 4
) (
    input  wire logic              clk,
    input  wire logic              clr_n,
    input  wire logic              en,
    input  wire logic              fixed_pri,
    glyph_fetch_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]    w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant_any;
    logic [ID_W-1:0]    w_sel;

    logic [ID_W-1:0]    r_rr_ptr;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [GLYPH_W-1:0] r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .i_en        (en),
        .i_fixed_pri (fixed_pri),
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    // Idle cycles present requester 0's slices; the bank ignores them.
    assign w_sel         = w_grant_any ? w_grant_idx : '0;
    assign bus.req_ready = w_grant;
    assign bus.rom_code  = bus.req_code[int'(w_sel)*CODE_W +: CODE_W];
    assign bus.rom_addr  = bus.req_row[int'(w_sel)*ROW_W +: ROW_W];

    // A grant is only ever issued to an asserted request, so grant == accept.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr    <= ID_W'(wrap_inc(int'(w_grant_idx), NREQ));
            r_rsp_valid <= w_grant;
            r_rsp_data  <= bus.rom_data;
            r_rsp_id    <= w_grant_idx;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_glyph_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_glyph_fetch_arbiter
// Brief    : Table-driven bench for glyph_fetch_arbiter with a ROM bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_glyph_fetch_arbiter;
    import glyph_fetch_arbiter_pkg::*;

    localparam int NREQ   = 4;
    localparam int CODE_W = 4;

    logic clk       = 1'b0;
    logic clr_n     = 1'b0;
    logic en        = 1'b0;
    logic fixed_pri = 1'b0;

    glyph_fetch_arbiter_if #(.NREQ(NREQ), .CODE_W(CODE_W)) bus ();

    glyph_fetch_arbiter #(
        .NREQ   (NREQ),
        .CODE_W (CODE_W)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .en        (en),
        .fixed_pri (fixed_pri),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_model(input logic [3:0] code, input logic [3:0] row);
        if (code == 4'hB && row == 4'd3) begin
            return 16'b1110000000000111;
        end
        return {code, row, ~row, code ^ row} ^ 16'h5A5A;
    endfunction

    always_comb bus.rom_data = rom_model(bus.rom_code, bus.rom_addr);

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    typedef struct {
        logic       en;
        logic       fp;
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_data = '0;
    logic [1:0]  exp_id   = '0;

    // Drive one cycle of requests, check the grant, then check the response.
    task automatic apply(input vec_t v, input int k);
        int g;
        en            = v.en;
        fixed_pri     = v.fp;
        bus.req_valid = v.valid;
        bus.req_code  = 16'h7C3B + 16'(k) * 16'h1111;
        bus.req_row   = 16'h9513 + 16'(k) * 16'h2222;
        #1;
        chk($sformatf("ready[%0d]", k), 32'(bus.req_ready), 32'(v.ready));
        if (v.ready != 4'b0000) begin
            g        = oh_idx(v.ready);
            exp_id   = 2'(g);
            exp_data = rom_model(bus.req_code[g*4 +: 4], bus.req_row[g*4 +: 4]);
        end
        @(posedge clk);
        #1;
        chk($sformatf("rsp_valid[%0d]", k), 32'(bus.rsp_valid), 32'(v.ready));
        chk($sformatf("rsp_id[%0d]", k), 32'(bus.rsp_id), 32'(exp_id));
        chk($sformatf("rsp_data[%0d]", k), 32'(bus.rsp_data), 32'(exp_data));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_code  = '0;
        bus.req_row   = '0;

        // Expected grants are hand-traced from the rr pointer after each vector.
        tbl.push_back('{1'b1, 1'b0, 4'b0001, 4'b0001}); // single request, glyph B row 3
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b0010}); // rotation from ptr 1
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b0100});
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b1000});
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b0001});
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b0010});
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b0100});
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b1000});
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b0001});
        tbl.push_back('{1'b1, 1'b1, 4'b1010, 4'b0010}); // fixed: 3 starves
        tbl.push_back('{1'b1, 1'b1, 4'b1010, 4'b0010});
        tbl.push_back('{1'b1, 1'b1, 4'b1010, 4'b0010});
        tbl.push_back('{1'b1, 1'b0, 4'b1010, 4'b1000}); // rr with ptr 2 -> 3
        tbl.push_back('{1'b1, 1'b0, 4'b1010, 4'b0010}); // ptr 0 -> 1
        tbl.push_back('{1'b0, 1'b0, 4'b0100, 4'b0000}); // en gating
        tbl.push_back('{1'b0, 1'b0, 4'b0100, 4'b0000});
        tbl.push_back('{1'b0, 1'b0, 4'b0100, 4'b0000});
        tbl.push_back('{1'b1, 1'b0, 4'b0100, 4'b0100}); // ptr becomes 3
        tbl.push_back('{1'b1, 1'b0, 4'b0001, 4'b0001}); // wrap 3 -> 0
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b0010}); // ptr was 1
        tbl.push_back('{1'b1, 1'b0, 4'b0110, 4'b0100}); // 1 pending, 2 wins
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000}); // 1 withdrawn
        tbl.push_back('{1'b1, 1'b1, 4'b0000, 4'b0000});

        #2;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_data", 32'(bus.rsp_data), 32'h0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            apply(tbl[k], k);
            if (k == 0) begin
                chk("glyph_b_row3", 32'(bus.rsp_data), 32'hE007);
            end
        end

        // Reset mid-operation: ptr is 3 here, so requester 2 wins.
        apply('{1'b1, 1'b0, 4'b0100, 4'b0100}, 23);
        bus.req_valid = '0;
        clr_n         = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("async_rst_data", 32'(bus.rsp_data), 32'h0);
        chk("async_rst_id", 32'(bus.rsp_id), 32'h0);
        exp_data = '0;
        exp_id   = '0;
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
        apply('{1'b1, 1'b0, 4'b1111, 4'b0001}, 24);
        apply('{1'b1, 1'b0, 4'b1111, 4'b0010}, 25);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
